// File: rtl/mux_pkg.sv
// Shared types and helpers for the multiplexed-row scanner.
// Row count, FSM state encoding and the one-hot row decoder.
package mux_pkg;

    localparam int NB_MUX_ROWS = 4;

    typedef enum logic [2:0] {IDLE, PRELOAD, SHIFT, HOLD, BLANK} mux_state_t;

    function automatic logic [NB_MUX_ROWS-1:0] onehot4(input logic [1:0] idx);
        logic [NB_MUX_ROWS-1:0] r;
        r = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/mux_row_scanner_if.sv
// Bundle between the row scanner (master) and the driver-shift / LUT side (slave).
// led/led_valid form a valid/ready pair: a transfer happens on any clock edge where
// led_valid && led_ready; led and led_valid stay stable while led_ready is low.
interface mux_row_scanner_if #(
    parameter int LED_WIDTH = 4
);
    import mux_pkg::*;

    logic                   run;
    logic                   led_ready;
    logic [NB_MUX_ROWS-1:0] row_en;
    logic [LED_WIDTH-1:0]   led;
    logic                   led_valid;
    logic                   latch;
    logic                   busy;
    mux_state_t             state;

    modport master (
        input  run, led_ready,
        output row_en, led, led_valid, latch, busy, state
    );

    modport slave (
        output run, led_ready,
        input  row_en, led, led_valid, latch, busy, state
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating cycle counter: clear restarts the count with the current cycle included,
// so done rises on the MAX-th cycle since the clear.
module sat_counter #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic done
);
    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = W'(1);
        end else if (enable && (cnt_q < MAX_V)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q >= MAX_V);

endmodule

// File: rtl/mux_row_scanner.sv
// Multiplexed-row sequencer: lights one row while loading the next row's driver data,
// then latches and blanks before switching rows.
module mux_row_scanner #(
    parameter int NB_LEDS_PER_GROUP = 16,
    parameter int ON_CYCLES         = 256,
    parameter int BLANK_CYCLES      = 4,
    localparam int LED_WIDTH        = $clog2(NB_LEDS_PER_GROUP)
) (
    input  logic              clk,
    input  logic              rst,
    mux_row_scanner_if.master bus
);
    import mux_pkg::*;

    localparam logic [LED_WIDTH-1:0] LED_LAST = LED_WIDTH'(NB_LEDS_PER_GROUP - 1);

    mux_state_t             state_q, state_d;
    logic [1:0]             cur_q, cur_d;
    logic [NB_MUX_ROWS-1:0] row_en_q, row_en_d;
    logic [LED_WIDTH-1:0]   led_q, led_d;
    logic                   led_valid_q, led_valid_d;
    logic                   latch_q, latch_d;
    logic                   busy_q, busy_d;

    logic xfer, last_xfer;
    logic on_done, blank_done;
    logic on_clear, on_en, blank_clear, blank_en;

    assign xfer      = led_valid_q && bus.led_ready;
    assign last_xfer = xfer && (led_q == LED_LAST);

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        row_en_d    = row_en_q;
        led_d       = led_q;
        led_valid_d = led_valid_q;
        latch_d     = 1'b0;
        busy_d      = busy_q;

        if (xfer) begin
            led_d = (led_q == LED_LAST) ? '0 : led_q + LED_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.run) begin
                    // cur parks on row 3 so the first post-preload increment lands on row 0
                    state_d     = PRELOAD;
                    cur_d       = 2'd3;
                    led_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            PRELOAD: begin
                if (last_xfer) begin
                    state_d     = BLANK;
                    led_valid_d = 1'b0;
                    latch_d     = 1'b1;
                end
            end
            SHIFT: begin
                if (last_xfer) begin
                    state_d     = HOLD;
                    led_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (on_done) begin
                    state_d  = BLANK;
                    row_en_d = '0;
                    latch_d  = 1'b1;
                end
            end
            BLANK: begin
                if (blank_done) begin
                    if (bus.run) begin
                        state_d     = SHIFT;
                        cur_d       = cur_q + 2'd1;
                        row_en_d    = onehot4(cur_q + 2'd1);
                        led_valid_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cur_d   = 2'd0;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The on-time window opens on the first lit cycle and spans SHIFT plus HOLD
    assign on_clear    = (state_q == BLANK) && blank_done && bus.run;
    assign on_en       = (state_q == SHIFT) || (state_q == HOLD);
    assign blank_clear = (state_d == BLANK) && (state_q != BLANK);
    assign blank_en    = (state_q == BLANK);

    sat_counter #(.MAX(ON_CYCLES)) u_on_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (on_clear),
        .enable (on_en),
        .done   (on_done)
    );

    sat_counter #(.MAX(BLANK_CYCLES)) u_blank_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (blank_clear),
        .enable (blank_en),
        .done   (blank_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_q       <= 2'd0;
            row_en_q    <= '0;
            led_q       <= '0;
            led_valid_q <= 1'b0;
            latch_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            row_en_q    <= row_en_d;
            led_q       <= led_d;
            led_valid_q <= led_valid_d;
            latch_q     <= latch_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.row_en    = row_en_q;
    assign bus.led       = led_q;
    assign bus.led_valid = led_valid_q;
    assign bus.latch     = latch_q;
    assign bus.busy      = busy_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_mux_row_scanner.sv
// Bench for mux_row_scanner: randomized led_ready / run stimulus checked each cycle
// against a phase-level model of row timing, latch pulses and the led transfer order.
module tb_mux_row_scanner;
    import mux_pkg::*;

    localparam int N  = 16;
    localparam int ON = 32;
    localparam int BL = 2;
    localparam int LW = $clog2(N);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_row_scanner_if #(.LED_WIDTH(LW)) sif ();

    mux_row_scanner #(
        .NB_LEDS_PER_GROUP (N),
        .ON_CYCLES         (ON),
        .BLANK_CYCLES      (BL)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, req);
        end
    endtask

    // Phase-level reference model
    typedef enum {P_IDLE, P_PRE, P_ROW, P_BLANK} ph_t;
    ph_t ph;
    logic [LW-1:0] exp_q[$];
    int exp_row, lit_len, blank_len, pre_len, stalls, rows_done;
    logic prev_stall, prev_run;
    logic [LW-1:0] prev_led;

    // Stimulus controls
    logic run_drv, rand_ready, long_arm, long_row, drop_arm;
    int long_cnt;

    function automatic int lut_row(input logic [3:0] r);
        int k;
        k = 0;
        for (int i = 0; i < 4; i++) if (r[i]) k = (i + 1) % 4;
        return k;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        ph = P_IDLE;
        exp_q.delete();
        exp_row = 0; lit_len = 0; blank_len = 0; pre_len = 0; stalls = 0;
        prev_stall = 1'b0; prev_run = 1'b0; prev_led = '0;
        long_cnt = 0; long_row = 1'b0;
    endtask

    task automatic push_load();
        for (int i = 0; i < N; i++) exp_q.push_back(LW'(i));
    endtask

    task automatic step();
        logic [3:0] ren;
        logic [LW-1:0] ld;
        logic vld, lat, bsy, lat_exp, rdy;
        int data_row;
        @(negedge clk);
        ren = sif.row_en; ld = sif.led; vld = sif.led_valid; lat = sif.latch; bsy = sif.busy;
        lat_exp = 1'b0;
        if (prev_stall) check("led_hold", ld, prev_led);
        case (ph)
            P_IDLE: if (bsy) begin
                check("start_run", prev_run, 1);
                ph = P_PRE; exp_row = 0; pre_len = 0; stalls = 0;
                push_load();
            end
            P_PRE: if (exp_q.size() == 0) begin
                check("pre_len", pre_len, N + stalls);
                ph = P_BLANK; blank_len = 0; lat_exp = 1'b1;
            end
            P_ROW: if (ren == 4'b0000) begin
                check("lit_len", lit_len, max2(ON, N + stalls + 1));
                if (long_row) check("lit_len_stall40", lit_len, 57);
                long_row = 1'b0;
                rows_done++;
                exp_row = (exp_row + 1) % 4;
                ph = P_BLANK; blank_len = 0; lat_exp = 1'b1;
            end else begin
                check("row_en_lit", ren, 4'b0001 << exp_row);
            end
            P_BLANK: if (ren != 4'b0000) begin
                check("blank_len", blank_len, BL);
                check("row_run", prev_run, 1);
                check("row_en_new", ren, 4'b0001 << exp_row);
                ph = P_ROW; lit_len = 0; stalls = 0;
                push_load();
            end else if (!bsy) begin
                check("blank_len_idle", blank_len, BL);
                check("idle_run", prev_run, 0);
                ph = P_IDLE;
            end
            default: ;
        endcase
        case (ph)
            P_PRE:   pre_len++;
            P_ROW:   lit_len++;
            P_BLANK: blank_len++;
            default: ;
        endcase
        check("latch", lat, lat_exp);
        check("led_valid", vld, exp_q.size() != 0);
        check("busy", bsy, ph != P_IDLE);
        if (exp_q.size() == 0) check("led_rest", ld, 0);
        if (ph == P_BLANK || ph == P_IDLE) check("row_off", ren, 0);

        if (long_cnt > 0) begin
            rdy = 1'b0; long_cnt--;
        end else if (long_arm && ph == P_ROW && ren == 4'b0010 && vld && ld == LW'(5)) begin
            rdy = 1'b0; long_cnt = 39; long_arm = 1'b0; long_row = 1'b1;
        end else if (rand_ready) begin
            rdy = ($urandom_range(0, 3) != 0);
        end else begin
            rdy = 1'b1;
        end
        if (drop_arm && ph == P_ROW && ren == 4'b0100) begin
            run_drv = 1'b0; drop_arm = 1'b0;
        end
        sif.led_ready = rdy;
        sif.run       = run_drv;

        if (vld && rdy) begin
            if (exp_q.size() == 0) begin
                check("xfer_unexpected", 1, 0);
            end else begin
                check("led_order", ld, exp_q.pop_front());
                data_row = (ph == P_PRE) ? 0 : (exp_row + 1) % 4;
                check("lut_row", lut_row(ren), data_row);
            end
        end
        if (vld && !rdy && (ph == P_PRE || ph == P_ROW)) stalls++;
        prev_stall = vld && !rdy;
        prev_led   = ld;
        prev_run   = run_drv;
    endtask

    task automatic run_rows(input int count, input string tag);
        int target;
        target = rows_done + count;
        for (int i = 0; i < 5000 && rows_done < target; i++) step();
        check(tag, rows_done >= target, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_row_en"}, sif.row_en, 0);
        check({tag, "_led"}, sif.led, 0);
        check({tag, "_led_valid"}, sif.led_valid, 0);
        check({tag, "_latch"}, sif.latch, 0);
        check({tag, "_busy"}, sif.busy, 0);
        check({tag, "_state"}, sif.state, IDLE);
    endtask

    initial begin
        logic hit;
        rst = 1'b1;
        sif.run = 1'b0;
        sif.led_ready = 1'b0;
        run_drv = 1'b0; rand_ready = 1'b0; long_arm = 1'b0; drop_arm = 1'b0;
        rows_done = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // Free-flowing scan: preload then rows 0..3 and wrap
        run_drv = 1'b1;
        run_rows(5, "rows_free_timeout");

        // 40-cycle stall at led 5 on row 1
        long_arm = 1'b1;
        run_rows(5, "rows_stall_timeout");
        check("stall_applied", long_arm, 0);

        // Random back-pressure
        rand_ready = 1'b1;
        run_rows(8, "rows_random_timeout");

        // Drop run during row 2, expect a clean finish into IDLE, then restart
        drop_arm = 1'b1;
        for (int i = 0; i < 3000 && !(ph == P_IDLE && !drop_arm); i++) step();
        check("drop_reached_idle", ph == P_IDLE, 1);
        repeat (5) step();
        check("idle_busy", sif.busy, 0);
        run_drv = 1'b1;
        run_rows(3, "rows_restart_timeout");

        // Asynchronous reset in the middle of row 2's shift at led 7
        rand_ready = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            step();
            hit = (ph == P_ROW) && (sif.row_en == 4'b0100) && (sif.led == LW'(7)) && sif.led_valid;
        end
        check("reset_point_reached", hit, 1);
        #2 rst = 1'b1;
        #1 check_outputs_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        run_drv = 1'b0;
        sif.run = 1'b0;
        model_reset();
        repeat (10) step();
        check_outputs_zero("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
